// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Byte-enable pattern for an access of 2^size bytes starting at lane offset.
  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_extract.sv
// Load data lane select with sign or zero extension.
`default_nettype none

module lsu_extract
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  offset,
  input  logic              unsigned_ld,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sign;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    keep = '1;
    sign = 1'b0;
    case (size)
      SZ_B: begin
        keep = DATA_W'(8'hFF);
        sign = shifted[7];
      end
      SZ_H: begin
        keep = DATA_W'(16'hFFFF);
        sign = shifted[15];
      end
      SZ_W: begin
        keep = DATA_W'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        keep = '1;
        sign = 1'b0;
      end
    endcase
  end

  // Bits above the access size are filled with the sign for signed loads.
  assign data = (shifted & keep) | ((!unsigned_ld && sign) ? ~keep : '0);

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// Load/store unit: request capture, lane steering, memory handshake with
// wait states and ack timeout, and a one-cycle response pulse to the core.
`default_nettype none

module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                busy,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_misalign,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state;
  logic              acc_we;
  logic              acc_unsigned;
  logic [1:0]        acc_size;
  logic [OFF_W-1:0]  acc_off;
  logic              err;
  logic              misalign;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] wdata_rep;
  logic [7:0]        be_full;
  logic [2:0]        req_off;
  logic              bad_req;

  assign req_off = 3'(req_addr[OFF_W-1:0]);
  assign be_full = be_mask(req_size, req_off);

  // A dword on a 32-bit bus cannot be issued and is reported as misaligned.
  always_comb begin
    bad_req = 1'b0;
    case (req_size)
      SZ_H:    bad_req = req_addr[0];
      SZ_W:    bad_req = |req_addr[1:0];
      SZ_D:    bad_req = (DATA_W == 32) || (|req_addr[2:0]);
      default: bad_req = 1'b0;
    endcase
  end

  always_comb begin
    wdata_rep = req_wdata;
    case (req_size)
      SZ_B:    for (int i = 0; i < NB; i++)     wdata_rep[8*i +: 8]   = req_wdata[7:0];
      SZ_H:    for (int i = 0; i < NB / 2; i++) wdata_rep[16*i +: 16] = req_wdata[15:0];
      SZ_W:    for (int i = 0; i < NB / 4; i++) wdata_rep[32*i +: 32] = req_wdata[31:0];
      default: wdata_rep = req_wdata;
    endcase
  end

  lsu_extract #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_extract (
    .rdata       (mem_rdata),
    .size        (acc_size),
    .offset      (acc_off),
    .unsigned_ld (acc_unsigned),
    .data        (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      acc_we       <= 1'b0;
      acc_unsigned <= 1'b0;
      acc_size     <= SZ_B;
      acc_off      <= '0;
      err          <= 1'b0;
      misalign     <= 1'b0;
      wait_cnt     <= '0;
      rdata        <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            acc_we       <= req_we;
            acc_size     <= req_size;
            acc_unsigned <= req_unsigned;
            acc_off      <= req_addr[OFF_W-1:0];
            rdata        <= '0;
            if (bad_req) begin
              err      <= 1'b1;
              misalign <= 1'b1;
              state    <= RESP;
            end else begin
              err       <= 1'b0;
              misalign  <= 1'b0;
              wait_cnt  <= '0;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_be    <= be_full[NB-1:0];
              mem_wdata <= wdata_rep;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (mem_ack) begin
            rdata <= acc_we ? '0 : ld_data;
            state <= RESP;
          end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
            err   <= 1'b1;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign mem_req      = (state == ACCESS);
  assign rsp_valid    = (state == RESP);
  assign rsp_err      = rsp_valid & err;
  assign rsp_misalign = rsp_valid & misalign;
  assign rsp_rdata    = rsp_valid ? rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a 32-bit instance (TIMEOUT=4) and a
// 64-bit instance (TIMEOUT=16) share stimulus, selected by sel.
`default_nettype none

module tb_lsu_ctrl;

  typedef struct {
    int          lat;   // cycles after the accepting edge until rsp_valid
    int          nreq;  // cycles with mem_req high
    logic        err;
    logic        mis;
    logic        we;
    logic [63:0] rdata;
    logic [63:0] be;
    logic [63:0] wdata;
    logic [31:0] addr;
  } exp_t;

  typedef struct {
    logic        s;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [63:0] rd;
    int          ackw;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sel, req_v, ack, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;

  logic        busy32, rv32, err32, mis32, mreq32, mwe32;
  logic [31:0] rd32, maddr32, mwd32;
  logic [3:0]  be32;
  logic        busy64, rv64, err64, mis64, mreq64, mwe64;
  logic [63:0] rd64, mwd64;
  logic [31:0] maddr64;
  logic [7:0]  be64;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .reset(reset), .req_valid(req_v & ~sel), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .busy(busy32), .rsp_valid(rv32), .rsp_rdata(rd32),
    .rsp_err(err32), .rsp_misalign(mis32), .mem_req(mreq32), .mem_we(mwe32),
    .mem_addr(maddr32), .mem_be(be32), .mem_wdata(mwd32), .mem_ack(ack & ~sel),
    .mem_rdata(mem_rdata[31:0])
  );

  lsu_ctrl #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(16)) dut64 (
    .clk(clk), .reset(reset), .req_valid(req_v & sel), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy64), .rsp_valid(rv64), .rsp_rdata(rd64),
    .rsp_err(err64), .rsp_misalign(mis64), .mem_req(mreq64), .mem_we(mwe64),
    .mem_addr(maddr64), .mem_be(be64), .mem_wdata(mwd64), .mem_ack(ack & sel),
    .mem_rdata(mem_rdata)
  );

  logic        m_busy, m_rv, m_err, m_mis, m_mreq, m_we;
  logic [63:0] m_rdata, m_wdata, m_be;
  logic [31:0] m_addr;
  assign m_busy  = sel ? busy64 : busy32;
  assign m_rv    = sel ? rv64   : rv32;
  assign m_err   = sel ? err64  : err32;
  assign m_mis   = sel ? mis64  : mis32;
  assign m_mreq  = sel ? mreq64 : mreq32;
  assign m_we    = sel ? mwe64  : mwe32;
  assign m_rdata = sel ? rd64   : {32'd0, rd32};
  assign m_wdata = sel ? mwd64  : {32'd0, mwd32};
  assign m_be    = sel ? {56'd0, be64} : {60'd0, be32};
  assign m_addr  = sel ? maddr64 : maddr32;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-by-byte view of the access, timing from wait-state count.
  function automatic exp_t model(input logic s, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [63:0] wd, input logic [63:0] rd, input int ackw);
    exp_t e;
    int nb, to, bytes, off;
    logic [63:0] v;
    nb = s ? 8 : 4;
    to = s ? 16 : 4;
    bytes = 1 << size;
    off = int'(addr[2:0]) % nb;
    e.we = we; e.rdata = '0; e.be = '0; e.wdata = '0; e.err = 1'b0; e.mis = 1'b0;
    e.addr = addr - 32'(off);
    if ((int'(addr[2:0]) % bytes) != 0 || bytes > nb) begin
      e.err = 1'b1; e.mis = 1'b1; e.lat = 1; e.nreq = 0;
      return e;
    end
    e.be = 64'((1 << bytes) - 1) << off;
    for (int i = 0; i < nb; i++) e.wdata[8*i +: 8] = wd[8*(i % bytes) +: 8];
    if (to != 0 && ackw >= to) begin
      e.err = 1'b1; e.lat = to + 1; e.nreq = to;
      return e;
    end
    e.lat = ackw + 2;
    e.nreq = ackw + 1;
    if (!we) begin
      v = '0;
      for (int k = 0; k < bytes; k++) v[8*k +: 8] = rd[8*(off + k) +: 8];
      if (!uns && v[8*bytes-1])
        for (int k = bytes; k < nb; k++) v[8*k +: 8] = 8'hFF;
      e.rdata = v;
    end
    return e;
  endfunction

  int          obs_lat, obs_nreq;
  logic        obs_got, obs_err, obs_mis, obs_we, obs_stable, obs_busy_ok;
  logic [63:0] obs_rdata, obs_be, obs_wdata;
  logic [31:0] obs_addr;

  task automatic run(input logic s, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                     input int ackw, input bit poke);
    int cyc;
    @(negedge clk);
    sel = s; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_v = 1'b1;
    @(negedge clk);
    req_v = 1'b0;
    cyc = 1; obs_got = 1'b0; obs_nreq = 0; obs_stable = 1'b1; obs_busy_ok = 1'b1;
    obs_err = 1'b0; obs_mis = 1'b0; obs_rdata = '0; obs_lat = 0;
    while (cyc < 40 && !obs_got) begin
      if (!m_busy) obs_busy_ok = 1'b0;
      if (m_mreq) begin
        if (obs_nreq == 0) begin
          obs_addr = m_addr; obs_be = m_be; obs_wdata = m_wdata; obs_we = m_we;
        end else if (m_addr !== obs_addr || m_be !== obs_be || m_wdata !== obs_wdata || m_we !== obs_we) begin
          obs_stable = 1'b0;
        end
        ack = (obs_nreq == ackw);
        mem_rdata = ack ? rd : {$urandom, $urandom};
        if (poke) begin
          req_v = 1'b1; req_addr = addr ^ 32'h40; req_we = ~we;
        end
        obs_nreq++;
      end else begin
        ack = 1'b0;
      end
      if (m_rv) begin
        obs_got = 1'b1; obs_lat = cyc; obs_err = m_err; obs_mis = m_mis;
        obs_rdata = m_rdata; req_v = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    ack = 1'b0;
    req_v = 1'b0;
  endtask

  task automatic compare(input string tag, input exp_t e);
    chk({tag, " rsp_seen"}, 64'(obs_got), 64'd1);
    if (!obs_got) return;
    chk({tag, " latency"}, 64'(obs_lat), 64'(e.lat));
    chk({tag, " mem_req_cycles"}, 64'(obs_nreq), 64'(e.nreq));
    chk({tag, " err/misalign"}, 64'({obs_err, obs_mis}), 64'({e.err, e.mis}));
    chk({tag, " rdata"}, obs_rdata, e.rdata);
    chk({tag, " busy_during"}, 64'(obs_busy_ok), 64'd1);
    if (e.nreq > 0 && obs_nreq > 0) begin
      chk({tag, " mem_addr"}, 64'(obs_addr), 64'(e.addr));
      chk({tag, " mem_be"}, obs_be, e.be);
      chk({tag, " mem_we"}, 64'(obs_we), 64'(e.we));
      chk({tag, " mem_stable"}, 64'(obs_stable), 64'd1);
      if (e.we) chk({tag, " mem_wdata"}, obs_wdata, e.wdata);
    end
    chk({tag, " idle_after"}, 64'({m_busy, m_rv}), 64'd0);
  endtask

  vec_t vecs[$];

  task automatic add(input logic s, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                     input int ackw, input int lat, input int nreq, input logic err,
                     input logic mis, input logic [63:0] rdata, input logic [63:0] be,
                     input logic [63:0] wdata, input logic [31:0] eaddr);
    vec_t v;
    v.s = s; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wd = wd; v.rd = rd;
    v.ackw = ackw;
    v.e.lat = lat; v.e.nreq = nreq; v.e.err = err; v.e.mis = mis; v.e.we = we;
    v.e.rdata = rdata; v.e.be = be; v.e.wdata = wdata; v.e.addr = eaddr;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    logic [31:0] r, a;
    logic [1:0] sz;
    logic s, seen;

    reset = 1'b1; sel = 1'b0; req_v = 1'b0; ack = 1'b0; req_we = 1'b0;
    req_unsigned = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0; mem_rdata = '0;

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      chk("reset ctrl outputs", 64'({m_busy, m_rv, m_err, m_mis, m_mreq, m_we}), 64'd0);
      chk("reset rdata", m_rdata, 64'd0);
      chk("reset addr/be", {m_addr, m_be[31:0]}, 64'd0);
      chk("reset wdata", m_wdata, 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    //  s  we size uns addr          wd                     rd                     ackw  lat nreq err mis rdata                  be     wdata                  addr
    add(0, 0, 2, 0, 32'h104, 64'h0, 64'hDEADBEEF, 2,   4, 3, 0, 0, 64'hDEADBEEF, 64'hF, 64'h0, 32'h104);
    add(0, 0, 0, 0, 32'h103, 64'h0, 64'h80FF1234, 0,   2, 1, 0, 0, 64'hFFFFFF80, 64'h8, 64'h0, 32'h100);
    add(0, 0, 0, 1, 32'h103, 64'h0, 64'h80FF1234, 0,   2, 1, 0, 0, 64'h00000080, 64'h8, 64'h0, 32'h100);
    add(0, 1, 1, 0, 32'h202, 64'hABCD, 64'hFFFFFFFF_FFFFFFFF, 1, 3, 2, 0, 0, 64'h0, 64'hC, 64'hABCDABCD, 32'h200);
    add(0, 0, 1, 0, 32'h301, 64'h0, 64'h0, 0,          1, 0, 1, 1, 64'h0, 64'h0, 64'h0, 32'h300);
    add(0, 0, 2, 0, 32'h010, 64'h0, 64'h0, 1000,       5, 4, 1, 0, 64'h0, 64'hF, 64'h0, 32'h010);
    add(0, 0, 2, 0, 32'h010, 64'h0, 64'h12345678, 3,   5, 4, 0, 0, 64'h12345678, 64'hF, 64'h0, 32'h010);
    add(1, 0, 3, 0, 32'h008, 64'h0, 64'h01234567_89ABCDEF, 1, 3, 2, 0, 0, 64'h01234567_89ABCDEF, 64'hFF, 64'h0, 32'h008);
    add(0, 0, 3, 0, 32'h008, 64'h0, 64'h0, 0,          1, 0, 1, 1, 64'h0, 64'h0, 64'h0, 32'h008);
    add(1, 0, 2, 0, 32'h00C, 64'h0, 64'h80000000_00000000, 0, 2, 1, 0, 0, 64'hFFFFFFFF_80000000, 64'hF0, 64'h0, 32'h008);
    add(1, 1, 0, 0, 32'h005, 64'h5A, 64'hFFFFFFFF_FFFFFFFF, 0, 2, 1, 0, 0, 64'h0, 64'h20, 64'h5A5A5A5A_5A5A5A5A, 32'h000);
    add(1, 0, 1, 1, 32'h006, 64'h0, 64'hBEEF0000_00000000, 0, 2, 1, 0, 0, 64'h0000BEEF, 64'hC0, 64'h0, 32'h000);

    foreach (vecs[i]) begin
      run(vecs[i].s, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wd,
          vecs[i].rd, vecs[i].ackw, 1'b0);
      compare($sformatf("vec%0d", i), vecs[i].e);
    end

    // Stray acks while idle must be ignored.
    sel = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ack = 1'b1; mem_rdata = {$urandom, $urandom};
      #1;
      chk("stray_ack idle", 64'({m_busy, m_mreq, m_rv}), 64'd0);
    end
    @(negedge clk);
    ack = 1'b0;
    chk("stray_ack after", 64'({m_busy, m_mreq, m_rv}), 64'd0);

    // Requests presented while busy are dropped.
    run(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 64'h0, 64'hCAFEF00D, 2, 1'b1);
    e = model(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 64'h0, 64'hCAFEF00D, 2);
    compare("busy_ignore", e);
    @(negedge clk);
    chk("busy_ignore no_accept", 64'({m_busy, m_rv}), 64'd0);

    // Asynchronous reset in the second ACCESS cycle abandons the access.
    @(negedge clk);
    sel = 1'b0; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h40; req_v = 1'b1;
    @(negedge clk);
    req_v = 1'b0;
    @(negedge clk);
    chk("async_rst mem_req before", 64'(m_mreq), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst drop", 64'({m_mreq, m_busy, m_rv}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m_rv || m_busy) seen = 1'b1;
    end
    chk("async_rst no_rsp", 64'(seen), 64'd0);
    run(1'b0, 1'b0, 2'd0, 1'b1, 32'h41, 64'h0, 64'h0000A500, 0, 1'b0);
    e = model(1'b0, 1'b0, 2'd0, 1'b1, 32'h41, 64'h0, 64'h0000A500, 0);
    compare("after_rst", e);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      s = r[0];
      sz = r[2:1];
      a = $urandom & 32'hFFFF;
      if ($urandom_range(3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      begin
        logic we_r, uns_r;
        logic [63:0] wd_r, rd_r;
        int w;
        we_r = r[3]; uns_r = r[4];
        wd_r = {$urandom, $urandom};
        rd_r = {$urandom, $urandom};
        w = $urandom_range(6);
        run(s, we_r, sz, uns_r, a, wd_r, rd_r, w, 1'b0);
        e = model(s, we_r, sz, uns_r, a, wd_r, rd_r, w);
        compare($sformatf("rand%0d", n), e);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
